adder_share_arbiter: RTL and testbench

Round-robin scheduler that shares one `conditional_sum_adder` instance among R requesters in the fpuFlow datapath. Each requester presents an operand pair with a valid/ready handshake. The block registers the granted operands, runs the adder for one cycle, and returns the sum, carry and requester ID through a backpressured response port. An optional carry-chain mode lets a requester build wide additions as successive N-bit words.

---
 rtl/adder_arb_pkg.sv | 21 ++
 rtl/conditional_sum_adder.sv | 52 +++++
 rtl/rr_arbiter.sv | 35 +++
 rtl/adder_share_arbiter.sv | 143 ++++++++++++++
 tb/tb_adder_share_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder_share_arbiter slice.
// Contents: FSM state enum, default N/K/R widths, and the requester-ID
// width helper used to size ptr/op_id/rsp_id.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } arb_state_e;

  localparam int DEF_N = 32;
  localparam int DEF_K = 4;
  localparam int DEF_R = 4;

  // Width of a requester index; never below one bit.
  function automatic int id_width(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/conditional_sum_adder.sv
// Block-wise conditional-sum adder: each K-bit block precomputes its sum for
// carry-in 0 and 1, and the incoming block carry selects between them.
// Purely combinational; the caller registers its inputs and outputs.
// Ports:
//   a, b  in  N  operands
//   cin   in  1  carry-in
//   sum   out N  a+b+cin modulo 2^N
//   cout  out 1  carry out of bit N-1
module conditional_sum_adder #(
  parameter int N = 32,
  parameter int K = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  // Operands are zero-padded to a whole number of blocks; with zero padding
  // the carry out of bit N-1 lands in bit N of the padded result.
  localparam int NB = (N + K - 1) / K;
  localparam int NP = NB * K;

  logic [NP-1:0] a_p, b_p, sum_p;
  logic [NP:0]   full;
  logic [K:0]    s0, s1, blk;
  logic          carry;

  assign a_p = NP'(a);
  assign b_p = NP'(b);

  always_comb begin
    carry = cin;
    sum_p = '0;
    s0    = '0;
    s1    = '0;
    blk   = '0;
    for (int i = 0; i < NB; i++) begin
      s0 = {1'b0, a_p[i*K +: K]} + {1'b0, b_p[i*K +: K]};
      s1 = s0 + (K+1)'(1);
      blk = carry ? s1 : s0;
      sum_p[i*K +: K] = blk[K-1:0];
      carry = blk[K];
    end
  end

  assign full = {carry, sum_p};
  assign sum  = full[N-1:0];
  assign cout = full[N];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req     in  R   pending request bits
//   ptr     in  IW  index of the last granted requester
//   grant   out R   one-hot grant (zero when req is zero)
//   gnt_idx out IW  index of the granted requester (0 when nothing granted)
// The scan starts at ptr+1 and wraps, so the last winner has lowest priority.
module rr_arbiter import adder_arb_pkg::*; #(
  parameter int R = DEF_R,
  localparam int IW = id_width(R)
) (
  input  logic [R-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [R-1:0]  grant,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin : pick
    int   j;
    logic found;
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 1; i <= R; i++) begin
      j = (int'(ptr) + i) % R;
      if (!found && req[j]) begin
        found      = 1'b1;
        grant[j]   = 1'b1;
        gnt_idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin scheduler sharing one conditional_sum_adder among R requesters.
// A granted operand pair is registered, added in the following cycle, and the
// result is held on a backpressured response port.
// Ports:
//   CLOCK_50   in  1    clock, all state on the rising edge
//   RESET      in  1    asynchronous active-high reset
//   req_valid  in  R    per-requester operation pending
//   req_ready  out R    one-hot grant, only while IDLE and out of reset
//   req_a/b    in  R*N  operands, slice i = [i*N +: N]
//   req_cin    in  R    per-requester carry-in
//   req_chain  in  R    use stored carry instead of req_cin
//                       (only with ADDER_ARB_CARRY_CHAIN_EN)
//   rsp_valid  out 1    response held
//   rsp_ready  in  1    consumer accepts the response
//   rsp_id     out IW   requester index of the response
//   rsp_sum    out N    A+B+cin modulo 2^N
//   rsp_cout   out 1    carry out of bit N-1
// Build option: ADDER_ARB_CARRY_CHAIN_EN adds req_chain and per-requester
// carry storage so wide additions can be issued as successive N-bit words.
//
// state | meaning
// IDLE  | waiting for a request; grants one and captures its operands
// EXEC  | adder works on the registered operands; result captured at the edge
// HOLD  | response valid, held until rsp_ready
module adder_share_arbiter import adder_arb_pkg::*; #(
  parameter int N = DEF_N,
  parameter int K = DEF_K,
  parameter int R = DEF_R,
  localparam int IW = id_width(R)
) (
  input  logic           CLOCK_50,
  input  logic           RESET,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  input  logic [R-1:0]   req_cin,
`ifdef ADDER_ARB_CARRY_CHAIN_EN
  input  logic [R-1:0]   req_chain,
`endif
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IW-1:0]  rsp_id,
  output logic [N-1:0]   rsp_sum,
  output logic           rsp_cout
);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q;
  logic [R-1:0]  grant;
  logic [IW-1:0] gnt_idx;
  logic          accept;
  logic          sel_cin;
  logic [N-1:0]  op_a, op_b;
  logic          op_cin;
  logic [IW-1:0] op_id;
  logic [N-1:0]  add_sum;
  logic          add_cout;

  rr_arbiter #(.R(R)) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .grant   (grant),
    .gnt_idx (gnt_idx)
  );

  conditional_sum_adder #(.N(N), .K(K)) u_add (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req_valid) state_d = EXEC;
      EXEC:    state_d = HOLD;
      HOLD:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    if (state_q == IDLE && !RESET) begin
      req_ready = grant;
      accept    = |req_valid;
    end
  end

`ifdef ADDER_ARB_CARRY_CHAIN_EN
  logic [R-1:0] carry_q;

  assign sel_cin = req_chain[gnt_idx] ? carry_q[gnt_idx] : req_cin[gnt_idx];

  // Only the requester whose word is in flight updates its stored carry.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET)                carry_q <= '0;
    else if (state_q == EXEC) carry_q[op_id] <= add_cout;
  end
`else
  assign sel_cin = req_cin[gnt_idx];
`endif

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      ptr_q     <= IW'(R-1);
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      if (accept) begin
        op_a   <= req_a[gnt_idx*N +: N];
        op_b   <= req_b[gnt_idx*N +: N];
        op_cin <= sel_cin;
        op_id  <= gnt_idx;
        ptr_q  <= gnt_idx;
      end
      if (state_q == EXEC) begin
        rsp_sum   <= add_sum;
        rsp_cout  <= add_cout;
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end else if (state_q == HOLD && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
module tb_adder_share_arbiter;
  localparam int N  = 32;
  localparam int K  = 4;
  localparam int R  = 4;
  localparam int IW = 2;

  logic           CLOCK_50 = 1'b0;
  logic           RESET;
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_a, req_b;
  logic [R-1:0]   req_cin;
  logic [R-1:0]   req_chain;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [N-1:0]   rsp_sum;
  logic           rsp_cout;

  int total = 0;
  int bad   = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  adder_share_arbiter #(.N(N), .K(K), .R(R)) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
`ifdef ADDER_ARB_CARRY_CHAIN_EN
    .req_chain (req_chain),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  // Round-robin rule: first pending requester after the last winner, wrapping.
  function automatic int rr_pick(input logic [R-1:0] v, input int last);
    int k;
    k = last;
    for (int n = 0; n < R; n++) begin
      k = (k + 1) % R;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  // Timing convention: tasks start and end 1 time unit after a rising edge;
  // inputs are driven there and outputs sampled 1 unit later.
  task automatic apply_reset();
    @(posedge CLOCK_50); #1;
    RESET = 1'b1; req_valid = '0; req_chain = '0; req_cin = '0; rsp_ready = 1'b1;
    @(posedge CLOCK_50); #1;
    @(posedge CLOCK_50); #1;
    RESET = 1'b0;
  endtask

  // Issues one operation from requester id with rsp_ready high and returns
  // the response; to=1 if the grant or response did not arrive in time.
  task automatic do_op(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic cin, input logic chain,
                       output logic [N-1:0] s, output logic co,
                       output logic [IW-1:0] rid, output bit to);
    int n;
    to = 1'b0; s = '0; co = 1'b0; rid = '0;
    req_a[id*N +: N] = a;
    req_b[id*N +: N] = b;
    req_cin[id]      = cin;
    req_chain[id]    = chain;
    req_valid[id]    = 1'b1;
    rsp_ready        = 1'b1;
    n = 0;
    #1;
    while (!req_ready[id] && n < 20) begin @(posedge CLOCK_50); #2; n++; end
    if (!req_ready[id]) to = 1'b1;
    @(posedge CLOCK_50); #1;
    req_valid[id] = 1'b0;
    #1;
    n = 0;
    while (!rsp_valid && n < 10) begin @(posedge CLOCK_50); #2; n++; end
    if (!rsp_valid) to = 1'b1;
    s = rsp_sum; co = rsp_cout; rid = rsp_id;
    @(posedge CLOCK_50); #1;
  endtask

  task automatic test_reset();
    @(posedge CLOCK_50); #2;
    total++;
    if (req_ready !== '0) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    total++;
    if ({rsp_valid, rsp_id, rsp_cout, rsp_sum} !== '0)
      begin bad++; $display("FAIL reset_rsp: got v=%b id=%0d c=%b s=%h want all zero", rsp_valid, rsp_id, rsp_cout, rsp_sum); end
    @(posedge CLOCK_50); #1;
    req_valid = '0; RESET = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_release: rsp_valid got %b want 0", rsp_valid); end
    @(posedge CLOCK_50); #1;
  endtask

  task automatic test_single();
    req_a[2*N +: N] = 32'hFFFF_FFFF; req_b[2*N +: N] = 32'h1; req_cin[2] = 1'b0;
    req_valid = 4'b0100; rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b want 0100", req_ready); end
    @(posedge CLOCK_50); #1;
    req_valid = '0;
    #1;
    total++;
    if (req_ready !== '0 || rsp_valid !== 1'b0)
      begin bad++; $display("FAIL single_exec: ready %b valid %b want 0000 0", req_ready, rsp_valid); end
    @(posedge CLOCK_50); #2;
    total++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 32'h0 || rsp_cout !== 1'b1 || rsp_id !== 2'd2)
      begin bad++; $display("FAIL single_rsp: got v=%b s=%h c=%b id=%0d want 1 0 1 2", rsp_valid, rsp_sum, rsp_cout, rsp_id); end
    @(posedge CLOCK_50); #2;
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_consumed: rsp_valid got %b want 0", rsp_valid); end
    @(posedge CLOCK_50); #1;
  endtask

  task automatic test_fairness();
    int order [5];
    int got, last, cyc, g;
    order = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < R; i++) begin
      req_a[i*N +: N] = $urandom; req_b[i*N +: N] = $urandom; req_cin[i] = 1'(i);
    end
    req_valid = '1; rsp_ready = 1'b1;
    got = 0; last = 0; cyc = 0;
    while (got < 5 && cyc < 40) begin
      #1;
      if (req_ready != '0) begin
        g = -1;
        for (int k = 0; k < R; k++) if (req_ready[k]) g = k;
        total++;
        if (!$onehot(req_ready) || g != order[got])
          begin bad++; $display("FAIL fair_order: got %b want index %0d", req_ready, order[got]); end
        if (got > 0) begin
          total++;
          if (cyc - last != 3) begin bad++; $display("FAIL fair_gap: got %0d cycles want 3", cyc - last); end
        end
        last = cyc;
        got++;
      end
      @(posedge CLOCK_50); #1;
      cyc++;
    end
    total++;
    if (got != 5) begin bad++; $display("FAIL fair_timeout: got %0d grants want 5", got); end
    req_valid = '0;
    repeat (4) begin @(posedge CLOCK_50); #1; end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] a1, b1, a3, b3;
    logic         c1, c3;
    logic [N:0]   e1, e3;
    apply_reset();
    a1 = $urandom; b1 = $urandom; c1 = 1'($urandom_range(1));
    a3 = $urandom; b3 = $urandom; c3 = 1'($urandom_range(1));
    e1 = {1'b0, a1} + {1'b0, b1} + {{N{1'b0}}, c1};
    e3 = {1'b0, a3} + {1'b0, b3} + {{N{1'b0}}, c3};
    req_a[1*N +: N] = a1; req_b[1*N +: N] = b1; req_cin[1] = c1;
    req_valid = 4'b0010; rsp_ready = 1'b0;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
    @(posedge CLOCK_50); #1;
    req_a[3*N +: N] = a3; req_b[3*N +: N] = b3; req_cin[3] = c3;
    req_valid = 4'b1000;
    #1;
    total++;
    if (req_ready !== '0) begin bad++; $display("FAIL bp_exec_ready: got %b want 0000", req_ready); end
    @(posedge CLOCK_50); #2;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || {rsp_cout, rsp_sum} !== e1 || req_ready !== '0)
        begin bad++; $display("FAIL bp_hold: cyc %0d v=%b id=%0d val=%h rdy=%b want 1 1 %h 0000", k, rsp_valid, rsp_id, {rsp_cout, rsp_sum}, req_ready, e1); end
      if (k < 5) begin @(posedge CLOCK_50); #2; end
    end
    rsp_ready = 1'b1;
    #1;
    total++;
    if (rsp_valid !== 1'b1 || req_ready !== '0)
      begin bad++; $display("FAIL bp_release: v=%b rdy=%b want 1 0000", rsp_valid, req_ready); end
    @(posedge CLOCK_50); #2;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b1000)
      begin bad++; $display("FAIL bp_next_grant: v=%b rdy=%b want 0 1000", rsp_valid, req_ready); end
    @(posedge CLOCK_50); #1;
    req_valid = '0;
    #1;
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_next_exec: v=%b want 0", rsp_valid); end
    @(posedge CLOCK_50); #2;
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || {rsp_cout, rsp_sum} !== e3)
      begin bad++; $display("FAIL bp_next_rsp: v=%b id=%0d val=%h want 1 3 %h", rsp_valid, rsp_id, {rsp_cout, rsp_sum}, e3); end
    @(posedge CLOCK_50); #1;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_a[1*N +: N] = $urandom; req_b[1*N +: N] = $urandom; req_cin[1] = 1'b1;
    req_valid = 4'b0010; rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin bad++; $display("FAIL rm_grant: got %b want 0010", req_ready); end
    @(posedge CLOCK_50); #1;
    req_valid = '1; RESET = 1'b1;
    #1;
    total++;
    if (req_ready !== '0 || rsp_valid !== 1'b0)
      begin bad++; $display("FAIL rm_in_reset: rdy=%b v=%b want 0000 0", req_ready, rsp_valid); end
    @(posedge CLOCK_50); #1;
    req_valid = '0; RESET = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rm_no_rsp: cyc %0d v=%b want 0", k, rsp_valid); end
      @(posedge CLOCK_50); #1;
    end
    req_valid = '1;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL rm_first_after: got %b want 0001", req_ready); end
    @(posedge CLOCK_50); #1;
    req_valid = '0;
    repeat (4) begin @(posedge CLOCK_50); #1; end
  endtask

`ifdef ADDER_ARB_CARRY_CHAIN_EN
  task automatic test_carry_chain();
    logic [N-1:0]  s;
    logic          co;
    logic [IW-1:0] rid;
    bit            to;
    apply_reset();
    do_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, s, co, rid, to);
    total++;
    if (to || {co, s} !== {1'b1, 32'hFFFF_FFFE} || rid !== 2'd3)
      begin bad++; $display("FAIL chain_r3_first: to=%b val=%h id=%0d want 0 1fffffffe 3", to, {co, s}, rid); end
    do_op(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, s, co, rid, to);
    total++;
    if (to || {co, s} !== {1'b1, 32'h0} || rid !== 2'd1)
      begin bad++; $display("FAIL chain_r1_low: to=%b val=%h id=%0d want 0 100000000 1", to, {co, s}, rid); end
    do_op(1, 32'h0, 32'h0, 1'b0, 1'b1, s, co, rid, to);
    total++;
    if (to || {co, s} !== {1'b0, 32'h1})
      begin bad++; $display("FAIL chain_r1_high: to=%b val=%h want 0 000000001", to, {co, s}); end
    do_op(1, 32'h0, 32'h0, 1'b1, 1'b1, s, co, rid, to);
    total++;
    if (to || {co, s} !== {1'b0, 32'h0})
      begin bad++; $display("FAIL chain_r1_cleared: to=%b val=%h want 0 000000000", to, {co, s}); end
    do_op(3, 32'h0, 32'h0, 1'b0, 1'b1, s, co, rid, to);
    total++;
    if (to || {co, s} !== {1'b0, 32'h1} || rid !== 2'd3)
      begin bad++; $display("FAIL chain_r3_kept: to=%b val=%h id=%0d want 0 000000001 3", to, {co, s}, rid); end
    req_chain = '0;
  endtask
`else
  task automatic test_macro_off();
    logic [N-1:0]  s;
    logic          co;
    logic [IW-1:0] rid;
    bit            to;
    apply_reset();
    do_op(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, s, co, rid, to);
    total++;
    if (to || {co, s} !== {1'b1, 32'h0} || rid !== 2'd1)
      begin bad++; $display("FAIL nochain_low: to=%b val=%h id=%0d want 0 100000000 1", to, {co, s}, rid); end
    do_op(1, 32'h0, 32'h0, 1'b0, 1'b1, s, co, rid, to);
    total++;
    if (to || {co, s} !== {1'b0, 32'h0})
      begin bad++; $display("FAIL nochain_high: to=%b val=%h want 0 000000000", to, {co, s}); end
    req_chain = '0;
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] ra [R];
    logic [N-1:0] rb [R];
    logic         rc [R];
    logic [R-1:0] clr, exp_rdy;
    logic [N:0]   exp_val;
    bit           outst, exp_rv;
    int           acc_cyc, exp_id, last, g;
    apply_reset();
    last = R - 1; outst = 1'b0; clr = '0; acc_cyc = 0; exp_id = 0; exp_val = '0;
    for (int i = 0; i < R; i++) begin ra[i] = '0; rb[i] = '0; rc[i] = 1'b0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < R; i++) begin
        if (clr[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i]) begin
          if ($urandom_range(2) == 0) begin
            ra[i] = $urandom; rb[i] = $urandom; rc[i] = 1'($urandom_range(1));
            req_a[i*N +: N] = ra[i]; req_b[i*N +: N] = rb[i]; req_cin[i] = rc[i];
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(15) == 0) req_valid[i] = 1'b0;
      end
      clr = '0;
      rsp_ready = ($urandom_range(3) != 0);
      #1;
      exp_rdy = '0;
      g = -1;
      if (!outst) g = rr_pick(req_valid, last);
      if (g >= 0) exp_rdy[g] = 1'b1;
      total++;
      if (req_ready !== exp_rdy) begin bad++; $display("FAIL rand_ready: cyc %0d got %b want %b", cyc, req_ready, exp_rdy); end
      exp_rv = outst && (cyc >= acc_cyc + 2);
      total++;
      if (rsp_valid !== exp_rv) begin bad++; $display("FAIL rand_valid: cyc %0d got %b want %b", cyc, rsp_valid, exp_rv); end
      if (exp_rv) begin
        total++;
        if (rsp_id !== IW'(exp_id) || {rsp_cout, rsp_sum} !== exp_val)
          begin bad++; $display("FAIL rand_rsp: cyc %0d id=%0d val=%h want id=%0d val=%h", cyc, rsp_id, {rsp_cout, rsp_sum}, exp_id, exp_val); end
        if (rsp_ready) outst = 1'b0;
      end
      if (g >= 0) begin
        outst = 1'b1; acc_cyc = cyc; exp_id = g; last = g; clr[g] = 1'b1;
        exp_val = {1'b0, ra[g]} + {1'b0, rb[g]} + {{N{1'b0}}, rc[g]};
      end
      @(posedge CLOCK_50); #1;
    end
    req_valid = '0; rsp_ready = 1'b1;
    repeat (4) begin @(posedge CLOCK_50); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET = 1'b1; req_valid = '1; req_a = '0; req_b = '0; req_cin = '0;
    req_chain = '0; rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_reset_mid();
`ifdef ADDER_ARB_CARRY_CHAIN_EN
    test_carry_chain();
`else
    test_macro_off();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
